// File: rtl/rmt_pkg.sv
// Shared types and AXIS widths for the RMT ingress path.
// Imported by the ingress arbiter and the rmt_wrapper benches.
`timescale 1ns/1ps
package rmt_pkg;

  localparam int AXIS_DATA_W   = 512;
  localparam int AXIS_USER_W   = 128;
  localparam int ARB_BURST_MAX = 4;
  localparam int ARB_CNT_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    GNT_CFG,
    GNT_DAT
  } arb_state_t;

endpackage

// File: rtl/rmt_ingress_arbiter.sv
// Packet-granular 2:1 AXIS arbiter: config stream has bounded
// priority over data; a granted packet is never interleaved.
`timescale 1ns/1ps
module rmt_ingress_arbiter
  import rmt_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = AXIS_DATA_W,
  parameter int C_S_AXIS_TUSER_WIDTH = AXIS_USER_W,
  parameter int CFG_BURST_MAX        = ARB_BURST_MAX,
  parameter int CNT_WIDTH            = ARB_CNT_W
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_cfg_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_cfg_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_cfg_axis_tuser,
  input  logic                              s_cfg_axis_tvalid,
  input  logic                              s_cfg_axis_tlast,
  output logic                              s_cfg_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_dat_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_dat_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_dat_axis_tuser,
  input  logic                              s_dat_axis_tvalid,
  input  logic                              s_dat_axis_tlast,
  output logic                              s_dat_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              data_pause,
  output logic                              cfg_active,
  output logic [CNT_WIDTH-1:0]              cfg_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              dat_pkt_cnt
);

  localparam int SW = $clog2(CFG_BURST_MAX + 1);
  localparam logic [SW-1:0] BURST = SW'(CFG_BURST_MAX);

  arb_state_t           state_q, state_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic [CNT_WIDTH-1:0] cfg_cnt_q, cfg_cnt_d;
  logic [CNT_WIDTH-1:0] dat_cnt_q, dat_cnt_d;

  logic cfg_req;
  logic dat_req;
  logic cfg_end;
  logic dat_end;

  always_comb begin
    cfg_req   = s_cfg_axis_tvalid;
    dat_req   = s_dat_axis_tvalid & ~data_pause;
    cfg_end   = s_cfg_axis_tvalid & m_axis_tready
              & s_cfg_axis_tlast;
    dat_end   = s_dat_axis_tvalid & m_axis_tready
              & s_dat_axis_tlast;
    state_d   = state_q;
    streak_d  = streak_q;
    cfg_cnt_d = cfg_cnt_q;
    dat_cnt_d = dat_cnt_q;
    unique case (state_q)
      IDLE: begin
        // streak < BURST here, so the increment cannot overshoot
        if (cfg_req && (!dat_req || streak_q < BURST)) begin
          state_d = GNT_CFG;
          if (dat_req) streak_d = streak_q + 1'b1;
        end else if (dat_req) begin
          state_d  = GNT_DAT;
          streak_d = '0;
        end
      end
      GNT_CFG: begin
        if (cfg_end) begin
          state_d   = IDLE;
          cfg_cnt_d = cfg_cnt_q + 1'b1;
        end
      end
      GNT_DAT: begin
        if (dat_end) begin
          state_d   = IDLE;
          dat_cnt_d = dat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      cfg_cnt_q <= '0;
      dat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      cfg_cnt_q <= cfg_cnt_d;
      dat_cnt_q <= dat_cnt_d;
    end
  end

  always_comb begin
    m_axis_tdata      = '0;
    m_axis_tkeep      = '0;
    m_axis_tuser      = '0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    s_cfg_axis_tready = 1'b0;
    s_dat_axis_tready = 1'b0;
    unique case (1'b1)
      (state_q == GNT_CFG): begin
        m_axis_tdata      = s_cfg_axis_tdata;
        m_axis_tkeep      = s_cfg_axis_tkeep;
        m_axis_tuser      = s_cfg_axis_tuser;
        m_axis_tvalid     = s_cfg_axis_tvalid;
        m_axis_tlast      = s_cfg_axis_tlast;
        s_cfg_axis_tready = m_axis_tready;
      end
      (state_q == GNT_DAT): begin
        m_axis_tdata      = s_dat_axis_tdata;
        m_axis_tkeep      = s_dat_axis_tkeep;
        m_axis_tuser      = s_dat_axis_tuser;
        m_axis_tvalid     = s_dat_axis_tvalid;
        m_axis_tlast      = s_dat_axis_tlast;
        s_dat_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign cfg_active  = (state_q == GNT_CFG);
  assign cfg_pkt_cnt = cfg_cnt_q;
  assign dat_pkt_cnt = dat_cnt_q;

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// Bench for rmt_ingress_arbiter: IDLE arbitration table plus
// scoreboarded packet sequences through queue-fed sources.
`timescale 1ns/1ps
module tb_rmt_ingress_arbiter;
  import rmt_pkg::*;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 128;
  localparam int CW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic  src;
    beat_t b;
  } exp_t;

  typedef struct {
    logic cv;
    logic dv;
    logic pause;
    int   grant;
  } vec_t;

  logic clk;
  logic aresetn;
  logic m_axis_tready;
  logic data_pause;

  wire [DW-1:0] s_cfg_axis_tdata, s_dat_axis_tdata, m_axis_tdata;
  wire [KW-1:0] s_cfg_axis_tkeep, s_dat_axis_tkeep, m_axis_tkeep;
  wire [UW-1:0] s_cfg_axis_tuser, s_dat_axis_tuser, m_axis_tuser;
  wire s_cfg_axis_tvalid, s_cfg_axis_tlast, s_cfg_axis_tready;
  wire s_dat_axis_tvalid, s_dat_axis_tlast, s_dat_axis_tready;
  wire m_axis_tvalid, m_axis_tlast, cfg_active;
  wire [CW-1:0] cfg_pkt_cnt, dat_pkt_cnt;

  logic  src_en;
  beat_t cfg_src_b, dat_src_b, cfg_tbl_b, dat_tbl_b;
  logic  cfg_src_v, dat_src_v, cfg_tbl_v, dat_tbl_v;
  beat_t cfg_bus, dat_bus;

  assign cfg_bus = src_en ? cfg_src_b : cfg_tbl_b;
  assign dat_bus = src_en ? dat_src_b : dat_tbl_b;
  assign s_cfg_axis_tvalid = src_en ? cfg_src_v : cfg_tbl_v;
  assign s_dat_axis_tvalid = src_en ? dat_src_v : dat_tbl_v;
  assign s_cfg_axis_tdata = cfg_bus.d;
  assign s_cfg_axis_tkeep = cfg_bus.k;
  assign s_cfg_axis_tuser = cfg_bus.u;
  assign s_cfg_axis_tlast = cfg_bus.l;
  assign s_dat_axis_tdata = dat_bus.d;
  assign s_dat_axis_tkeep = dat_bus.k;
  assign s_dat_axis_tuser = dat_bus.u;
  assign s_dat_axis_tlast = dat_bus.l;

  beat_t cfg_q[$];
  beat_t dat_q[$];
  exp_t  exp_q[$];

  int   vecs;
  int   errs;
  int   beats_seen;
  int   act_cycles;
  logic mon_en;
  logic tog_en;
  logic rdy_val;

  rmt_ingress_arbiter dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .s_cfg_axis_tdata  (s_cfg_axis_tdata),
    .s_cfg_axis_tkeep  (s_cfg_axis_tkeep),
    .s_cfg_axis_tuser  (s_cfg_axis_tuser),
    .s_cfg_axis_tvalid (s_cfg_axis_tvalid),
    .s_cfg_axis_tlast  (s_cfg_axis_tlast),
    .s_cfg_axis_tready (s_cfg_axis_tready),
    .s_dat_axis_tdata  (s_dat_axis_tdata),
    .s_dat_axis_tkeep  (s_dat_axis_tkeep),
    .s_dat_axis_tuser  (s_dat_axis_tuser),
    .s_dat_axis_tvalid (s_dat_axis_tvalid),
    .s_dat_axis_tlast  (s_dat_axis_tlast),
    .s_dat_axis_tready (s_dat_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tready     (m_axis_tready),
    .data_pause        (data_pause),
    .cfg_active        (cfg_active),
    .cfg_pkt_cnt       (cfg_pkt_cnt),
    .dat_pkt_cnt       (dat_pkt_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time expired, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic last,
                                    input logic [KW-1:0] lk);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom;
    for (int i = 0; i < UW / 32; i++) b.u[i*32 +: 32] = $urandom;
    b.k = last ? lk : '1;
    b.l = last;
    return b;
  endfunction

  task automatic push_pkt(input logic src, input int n,
                          input logic [KW-1:0] lk);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < n; i++) begin
      b = mk_beat(i == n - 1, lk);
      if (src) cfg_q.push_back(b);
      else dat_q.push_back(b);
      e.src = src;
      e.b   = b;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (exp_q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL %s timeout: %0d beats left, want 0",
               nm, exp_q.size());
      exp_q.delete();
      cfg_q.delete();
      dat_q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    aresetn = 1'b0;
    exp_q.delete();
    cfg_q.delete();
    dat_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    aresetn = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin : cfg_drv
    logic hs;
    cfg_src_v = 1'b0;
    cfg_src_b = '0;
    forever begin
      @(negedge clk);
      hs = s_cfg_axis_tvalid && s_cfg_axis_tready && src_en;
      @(posedge clk);
      #1;
      if (hs && cfg_q.size() > 0) cfg_q.delete(0);
      cfg_src_v = (cfg_q.size() > 0);
      if (cfg_q.size() > 0) cfg_src_b = cfg_q[0];
    end
  end

  initial begin : dat_drv
    logic hs;
    dat_src_v = 1'b0;
    dat_src_b = '0;
    forever begin
      @(negedge clk);
      hs = s_dat_axis_tvalid && s_dat_axis_tready && src_en;
      @(posedge clk);
      #1;
      if (hs && dat_q.size() > 0) dat_q.delete(0);
      dat_src_v = (dat_q.size() > 0);
      if (dat_q.size() > 0) dat_src_b = dat_q[0];
    end
  end

  initial begin : rdy_drv
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) m_axis_tready = ~m_axis_tready;
      else m_axis_tready = rdy_val;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (cfg_active) act_cycles++;
      if (mon_en && s_cfg_axis_tready && s_dat_axis_tready) begin
        vecs++;
        errs++;
        $display("FAIL both_ready: got 1/1 want at most one");
      end
      if (mon_en && aresetn && m_axis_tvalid && m_axis_tready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL extra_beat: got beat %0h want none",
                   m_axis_tdata[31:0]);
        end else begin
          e = exp_q.pop_front();
          chk("beat_src", DW'(cfg_active), DW'(e.src));
          chk("beat_data", m_axis_tdata, e.b.d);
          chk("beat_keep", DW'(m_axis_tkeep), DW'(e.b.k));
          chk("beat_user", DW'(m_axis_tuser), DW'(e.b.u));
          chk("beat_last", DW'(m_axis_tlast), DW'(e.b.l));
        end
      end
    end
  end

  initial begin : main
    vec_t tbl[11];
    int   base;
    logic [3:0] want;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1};

    vecs       = 0;
    errs       = 0;
    beats_seen = 0;
    act_cycles = 0;
    mon_en     = 1'b0;
    tog_en     = 1'b0;
    rdy_val    = 1'b1;
    src_en     = 1'b0;
    data_pause = 1'b0;
    cfg_tbl_v  = 1'b0;
    dat_tbl_v  = 1'b0;
    cfg_tbl_b  = '0;
    dat_tbl_b  = '0;
    aresetn    = 1'b1;

    // reset window 10..20 ns, both sources idle
    #10;
    aresetn = 1'b0;
    #2;
    chk("rst_tvalid", DW'(m_axis_tvalid), '0);
    chk("rst_cfg_rdy", DW'(s_cfg_axis_tready), '0);
    chk("rst_dat_rdy", DW'(s_dat_axis_tready), '0);
    chk("rst_active", DW'(cfg_active), '0);
    chk("rst_cfg_cnt", DW'(cfg_pkt_cnt), '0);
    chk("rst_dat_cnt", DW'(dat_pkt_cnt), '0);
    #8;
    aresetn = 1'b1;
    @(posedge clk);
    #2;

    // single-beat arbitration table from IDLE, streak starts at 0
    cfg_tbl_b = mk_beat(1'b1, '1);
    dat_tbl_b = mk_beat(1'b1, '1);
    for (int i = 0; i < 11; i++) begin
      cfg_tbl_v  = tbl[i].cv;
      dat_tbl_v  = tbl[i].dv;
      data_pause = tbl[i].pause;
      @(posedge clk);
      @(negedge clk);
      want = {tbl[i].grant != 0, tbl[i].grant == 1,
              tbl[i].grant == 1, tbl[i].grant == 2};
      chk($sformatf("tbl%0d_ctl", i),
          DW'({m_axis_tvalid, cfg_active,
               s_cfg_axis_tready, s_dat_axis_tready}),
          DW'(want));
      if (tbl[i].grant != 0)
        chk($sformatf("tbl%0d_data", i), m_axis_tdata,
            (tbl[i].grant == 1) ? cfg_tbl_b.d : dat_tbl_b.d);
      @(posedge clk);
      #2;
    end
    cfg_tbl_v  = 1'b0;
    dat_tbl_v  = 1'b0;
    data_pause = 1'b0;
    chk("tbl_cfg_cnt", DW'(cfg_pkt_cnt), DW'(7));
    chk("tbl_dat_cnt", DW'(dat_pkt_cnt), DW'(2));

    src_en = 1'b1;
    mon_en = 1'b1;

    // lone 2-beat config packet with a partial last keep
    do_reset();
    act_cycles = 0;
    push_pkt(1'b1, 2, 64'h00000000000fffff);
    wait_done("t2", 20);
    chk("t2_cfg_cnt", DW'(cfg_pkt_cnt), DW'(1));
    chk("t2_dat_cnt", DW'(dat_pkt_cnt), '0);
    chk("t2_active_cycles", DW'(act_cycles), DW'(2));

    // both ports saturated: C,C,C,C,D,C,C,C,C,D
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) push_pkt(1'b1, 2, '1);
      push_pkt(1'b0, 2, '1);
    end
    wait_done("t3", 100);
    chk("t3_cfg_cnt", DW'(cfg_pkt_cnt), DW'(8));
    chk("t3_dat_cnt", DW'(dat_pkt_cnt), DW'(2));

    // data_pause holds off a waiting data packet
    do_reset();
    data_pause = 1'b1;
    base = beats_seen;
    push_pkt(1'b0, 2, '1);
    repeat (100) @(negedge clk);
    #1;
    chk("t4_paused_beats", DW'(beats_seen - base), '0);
    chk("t4_paused_cnt", DW'(dat_pkt_cnt), '0);
    @(posedge clk);
    #2;
    data_pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      if (beats_seen > base) break;
    end
    chk("t4_resume", DW'(beats_seen > base), DW'(1));
    wait_done("t4", 20);
    chk("t4_dat_cnt", DW'(dat_pkt_cnt), DW'(1));

    // toggling backpressure, config arrives mid data packet
    do_reset();
    tog_en = 1'b1;
    push_pkt(1'b0, 3, 64'h000000000000ffff);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (m_axis_tvalid && !cfg_active) break;
    end
    chk("t5_dat_granted", DW'(m_axis_tvalid && !cfg_active), DW'(1));
    @(posedge clk);
    #2;
    push_pkt(1'b1, 2, 64'h00000000000000ff);
    wait_done("t5", 40);
    tog_en  = 1'b0;
    rdy_val = 1'b1;
    chk("t5_cfg_cnt", DW'(cfg_pkt_cnt), DW'(1));
    chk("t5_dat_cnt", DW'(dat_pkt_cnt), DW'(1));

    // async reset on beat 2 of 3, counters carry 1/1 into it
    base = beats_seen;
    push_pkt(1'b1, 3, '1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (beats_seen == base + 1) break;
    end
    chk("t6_first_beat", DW'(beats_seen - base), DW'(1));
    @(posedge clk);
    #3;
    aresetn = 1'b0;
    #1;
    chk("t6_tvalid", DW'(m_axis_tvalid), '0);
    chk("t6_cfg_rdy", DW'(s_cfg_axis_tready), '0);
    chk("t6_active", DW'(cfg_active), '0);
    chk("t6_cfg_cnt0", DW'(cfg_pkt_cnt), '0);
    chk("t6_dat_cnt0", DW'(dat_pkt_cnt), '0);
    exp_q.delete();
    cfg_q.delete();
    dat_q.delete();
    @(posedge clk);
    #3;
    aresetn = 1'b1;
    @(posedge clk);
    #2;
    push_pkt(1'b1, 1, 64'h00000000000000ff);
    wait_done("t6", 20);
    chk("t6_cfg_cnt", DW'(cfg_pkt_cnt), DW'(1));
    chk("t6_dat_cnt", DW'(dat_pkt_cnt), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
